// File: rtl/fp32_add_arbiter_if.sv
// Bus bundle between requesters, the arbiter and the shared FP32 adder.
// The master side is the environment: it presents requests and returns
// the adder result. The slave side is the arbiter itself.
interface fp32_add_arbiter_if #(
  parameter int N_REQ = 4
) ();
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]    req_valid;
  logic [32*N_REQ-1:0] req_a;
  logic [32*N_REQ-1:0] req_b;
  logic [N_REQ-1:0]    req_ready;
  logic [31:0]         add_a;
  logic [31:0]         add_b;
  logic [31:0]         add_o;
  logic                rsp_valid;
  logic [IW-1:0]       rsp_id;
  logic [31:0]         rsp_data;

  modport master (
    output req_valid, req_a, req_b, add_o,
    input  req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_a, req_b, add_o,
    output req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/fp32_add_arbiter.sv
// Round-robin arbiter sharing one fixed-latency FP32 adder among N_REQ
// requesters. One operand pair is issued per cycle; a {valid, id} tag
// travels alongside the adder pipeline so each result is returned with the
// index of its owner, in issue order. Operand values are never inspected.
module fp32_add_arbiter #(
  parameter int N_REQ = 4,
  parameter int LAT   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fp32_add_arbiter_if.slave     bus,
  output logic                  busy,
  output logic [15:0]           issue_cnt
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [IW-1:0]  rr_reg;
  logic [IW-1:0]  rr_next;
  logic [31:0]    op_a [N_REQ];
  logic [31:0]    op_b [N_REQ];
  logic           found;
  logic [IW-1:0]  winner;
  logic           accept;
  logic [LAT-1:0] tag_valid_reg;
  logic [IW-1:0]  tag_id_reg [LAT];
  logic [15:0]    cnt_reg;

  // Unpack the flat operand buses and build the per-requester grant bits.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_req
      assign op_a[gi]          = bus.req_a[32*gi +: 32];
      assign op_b[gi]          = bus.req_b[32*gi +: 32];
      assign bus.req_ready[gi] = accept && (winner == IW'(gi));
    end
  endgenerate

  // First valid requester at or after the round-robin pointer, wrapping.
  // N_REQ is a power of two, so IW-bit addition wraps modulo N_REQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && bus.req_valid[rr_reg + IW'(k)]) begin
        found  = 1'b1;
        winner = rr_reg + IW'(k);
      end
    end
  end

  // No grants are offered while reset is held.
  assign accept    = found && rst_n;
  assign rr_next   = accept ? winner + IW'(1) : rr_reg;
  assign bus.add_a = accept ? op_a[winner] : 32'h0;
  assign bus.add_b = accept ? op_b[winner] : 32'h0;

  // Round-robin pointer moves just past the winner on every acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_reg <= '0;
    else        rr_reg <= rr_next;
  end

  // Tag shift register mirrors the adder pipeline; it never stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_valid_reg <= '0;
      for (int s = 0; s < LAT; s++) tag_id_reg[s] <= '0;
    end else begin
      tag_valid_reg[0] <= accept;
      tag_id_reg[0]    <= winner;
      for (int s = 1; s < LAT; s++) begin
        tag_valid_reg[s] <= tag_valid_reg[s-1];
        tag_id_reg[s]    <= tag_id_reg[s-1];
      end
    end
  end

  // Saturating count of accepted requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            cnt_reg <= 16'h0;
    else if (accept && cnt_reg != 16'hFFFF) cnt_reg <= cnt_reg + 16'h1;
  end

  assign bus.rsp_valid = tag_valid_reg[LAT-1];
  assign bus.rsp_id    = tag_id_reg[LAT-1];
  assign bus.rsp_data  = bus.add_o;
  assign busy          = |tag_valid_reg;
  assign issue_cnt     = cnt_reg;
endmodule

// File: tb/tb_fp32_add_arbiter.sv
// Directed bench for fp32_add_arbiter: a reference model of the round-robin
// grant rules and response timing is checked every cycle, and literal
// expectations for the classic scenarios pin that model.
module tb_fp32_add_arbiter;
  localparam int N   = 4;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        busy;
  logic [15:0] issue_cnt;

  fp32_add_arbiter_if #(.N_REQ(N)) bus ();

  fp32_add_arbiter #(.N_REQ(N), .LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .busy      (busy),
    .issue_cnt (issue_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // FP32 <-> real through the double-precision bit layout (normals and zero).
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'h0) return 0.0;
    d = {f[31], 11'(f[30:23]) - 11'd127 + 11'd1023, f[22:0], 29'h0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'h0) return {d[63], 31'h0};
    e = d[62:52] - 11'd1023 + 11'd127;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) + f2r(b));
  endfunction

  // Shared adder of the environment: LAT cycles from operands to sum.
  logic [31:0] pa [LAT];
  logic [31:0] pb [LAT];
  always @(posedge clk) begin
    pa[0] <= bus.add_a;
    pb[0] <= bus.add_b;
    for (int s = 1; s < LAT; s++) begin
      pa[s] <= pa[s-1];
      pb[s] <= pb[s-1];
    end
  end
  assign bus.add_o = fp_add(pa[LAT-1], pb[LAT-1]);

  // Reference model: expected grant from the rotating search, expected
  // responses scheduled LAT cycles ahead in a small cycle-indexed ring.
  int          rr_m  = 0;
  int          cnt_m = 0;
  int          cyc   = 0;
  bit          ev [8];
  int          eid [8];
  logic [31:0] edat [8];

  always @(negedge clk) begin : model
    bit f;
    int w;
    bit busy_e;
    logic [31:0] wa;
    logic [31:0] wb;
    if (!rst_n) begin
      rr_m  = 0;
      cnt_m = 0;
      for (int s = 0; s < 8; s++) ev[s] = 1'b0;
      chk("reset ready", 32'(bus.req_ready), 32'h0);
      chk("reset rsp_valid", 32'(bus.rsp_valid), 32'h0);
      chk("reset busy", 32'(busy), 32'h0);
      chk("reset issue_cnt", 32'(issue_cnt), 32'h0);
    end else begin
      f = 1'b0;
      w = 0;
      for (int k = 0; k < N; k++) begin
        if (!f && bus.req_valid[(rr_m + k) % N]) begin
          f = 1'b1;
          w = (rr_m + k) % N;
        end
      end
      wa = f ? bus.req_a[32*w +: 32] : 32'h0;
      wb = f ? bus.req_b[32*w +: 32] : 32'h0;
      chk("grant", 32'(bus.req_ready), f ? (32'd1 << w) : 32'd0);
      chk("add_a", bus.add_a, wa);
      chk("add_b", bus.add_b, wb);
      busy_e = 1'b0;
      for (int s = 0; s < LAT; s++) busy_e |= ev[(cyc + s) % 8];
      chk("busy", 32'(busy), 32'(busy_e));
      chk("issue_cnt", 32'(issue_cnt), 32'(cnt_m));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(ev[cyc % 8]));
      if (ev[cyc % 8]) begin
        chk("rsp_id", 32'(bus.rsp_id), 32'(eid[cyc % 8]));
        chk("rsp_data", bus.rsp_data, edat[cyc % 8]);
      end
      ev[cyc % 8] = 1'b0;
      if (f) begin
        rr_m = (w + 1) % N;
        if (cnt_m != 32'hFFFF) cnt_m++;
        ev[(cyc + LAT) % 8]   = 1'b1;
        eid[(cyc + LAT) % 8]  = w;
        edat[(cyc + LAT) % 8] = fp_add(wa, wb);
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Whole-run bound.
  initial begin
    #3000000;
    $display("FAIL watchdog: run did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int order [8];
    order = '{0, 1, 2, 3, 0, 1, 2, 3};

    // Operands: requester i adds (i+1).0 + 2.0.
    rst_n         = 1'b0;
    bus.req_valid = 4'hF;
    bus.req_a     = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
    bus.req_b     = {4{32'h40000000}};
    sample();
    chk("lit reset ready gated", 32'(bus.req_ready), 32'h0);
    tick();
    bus.req_valid = 4'h0;
    tick();
    rst_n = 1'b1;

    // Single request from requester 2: 1.0 + 2.0 = 3.0.
    tick();
    bus.req_valid = 4'b0100;
    bus.req_a[64 +: 32] = 32'h3F800000;
    sample();
    chk("lit single grant", 32'(bus.req_ready), 32'h4);
    chk("lit single add_a", bus.add_a, 32'h3F800000);
    for (int c = 0; c < LAT; c++) begin
      tick();
      bus.req_valid = 4'h0;
      sample();
    end
    chk("lit single rsp_valid", 32'(bus.rsp_valid), 32'h1);
    chk("lit single rsp_id", 32'(bus.rsp_id), 32'h2);
    chk("lit single rsp_data", bus.rsp_data, 32'h40400000);
    chk("lit single issue_cnt", 32'(issue_cnt), 32'h1);
    bus.req_a[64 +: 32] = 32'h40400000;

    // Full contention from reset: grants and responses rotate with no gaps.
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int j = 0; j < 8 + LAT; j++) begin
      tick();
      bus.req_valid = (j < 8) ? 4'hF : 4'h0;
      sample();
      if (j < 8) chk("lit rr grant", 32'(bus.req_ready), 32'd1 << order[j]);
      if (j >= LAT) begin
        chk("lit rr rsp_valid", 32'(bus.rsp_valid), 32'h1);
        chk("lit rr rsp_id", 32'(bus.rsp_id), 32'(order[j - LAT]));
      end
    end

    // Sparse contention: one grant to 1 leaves rr=2, then 3,1,3.
    tick();
    bus.req_valid = 4'b0010;
    sample();
    chk("lit sparse setup", 32'(bus.req_ready), 32'h2);
    for (int j = 0; j < 3; j++) begin
      tick();
      bus.req_valid = 4'b1010;
      sample();
      chk("lit sparse grant", 32'(bus.req_ready), (j == 1) ? 32'h2 : 32'h8);
    end

    // Idle: nothing offered, pipeline drains, pointer keeps its value.
    for (int j = 0; j < LAT + 2; j++) begin
      tick();
      bus.req_valid = 4'h0;
      sample();
      chk("lit idle add_a", bus.add_a, 32'h0);
      chk("lit idle ready", 32'(bus.req_ready), 32'h0);
    end
    chk("lit idle busy", 32'(busy), 32'h0);
    tick();
    bus.req_valid = 4'hF;
    sample();
    chk("lit idle rr held", 32'(bus.req_ready), 32'h1);

    // Reset mid-flight: two issues, then reset discards both.
    for (int j = 0; j < 2; j++) begin
      tick();
      sample();
      chk("lit flight grant", 32'(bus.req_ready), (j == 0) ? 32'h2 : 32'h4);
    end
    tick();
    rst_n         = 1'b0;
    bus.req_valid = 4'h0;
    tick();
    rst_n = 1'b1;
    for (int j = 0; j < LAT + 1; j++) begin
      sample();
      chk("lit flight rsp_valid", 32'(bus.rsp_valid), 32'h0);
      chk("lit flight busy", 32'(busy), 32'h0);
      chk("lit flight issue_cnt", 32'(issue_cnt), 32'h0);
      tick();
    end
    bus.req_valid = 4'hF;
    sample();
    chk("lit flight rr reset", 32'(bus.req_ready), 32'h1);

    // Saturation: keep everyone valid past 65535 acceptances.
    for (int j = 0; j < 65540; j++) tick();
    sample();
    chk("lit sat issue_cnt", 32'(issue_cnt), 32'hFFFF);
    for (int j = 0; j < 3; j++) tick();
    sample();
    chk("lit sat hold", 32'(issue_cnt), 32'hFFFF);
    tick();
    bus.req_valid = 4'h0;
    for (int j = 0; j < LAT + 1; j++) tick();
    sample();
    chk("lit drain busy", 32'(busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/fp32_add_arbiter.md
FP32_ADD_ARBITER -- requirements
Module: fp32_add_arbiter

Interface
REQ-001 Parameter: N_REQ, default 4, number of requesters (power of two, 2..8).
REQ-002 Parameter: LAT, default 2, fixed adder latency in cycles from operand-present cycle to result-valid cycle (1..4).
REQ-003 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-004 Port: clk  in  1  rising-edge clock for all state.
REQ-005 Port: rst_n  in  1  asynchronous active-low reset.
REQ-006 Port: req_valid  in  N_REQ  per-requester operand-pair valid.
REQ-007 Port: req_a  in  32*N_REQ  FP32 operand A; requester i in bits [32i+31:32i].
REQ-008 Port: req_b  in  32*N_REQ  FP32 operand B; same packing as req_a.
REQ-009 Port: req_ready  out  N_REQ  one-hot (or zero) grant; transfer occurs when valid and ready are both 1.
REQ-010 Port: add_a  out  32  operand A to the shared FP32 adder.
REQ-011 Port: add_b  out  32  operand B to the shared FP32 adder.
REQ-012 Port: add_o  in  32  shared adder result.
REQ-013 Port: rsp_valid  out  1  result strobe, one cycle per accepted request; no backpressure.
REQ-014 Port: rsp_id  out  log2(N_REQ)  index of the requester owning rsp_data.
REQ-015 Port: rsp_data  out  32  FP32 sum, equal to add_o.
REQ-016 Port: busy  out  1  at least one operation in flight.
REQ-017 Port: issue_cnt  out  16  total accepted requests, saturating.

Function
REQ-018 At most one request SHALL be accepted per cycle.
REQ-019 Grant SHALL be round-robin: the winner is the first asserted req_valid at or after pointer rr, searching upward modulo N_REQ.
REQ-020 req_ready SHALL be combinational from req_valid and rr: 1 only for the winner, all zero when no req_valid is set.
REQ-021 On acceptance, rr SHALL become (winner+1) mod N_REQ; with no acceptance, rr SHALL hold.
REQ-022 add_a and add_b SHALL combinationally carry the winner's operands in the grant cycle, and 32'h0 when there is no winner.
REQ-023 A requester SHALL hold req_a and req_b stable while valid and not ready; req_valid may drop without a transfer, and the block SHALL NOT depend on it staying high.
REQ-024 Tag pipeline: a LAT-deep shift register of {valid, id}; stage 0 is loaded with {accept, winner} at each edge, and every stage shifts every cycle with no stall.
REQ-025 rsp_valid and rsp_id SHALL equal the last tag stage; rsp_data SHALL equal add_o. An accepted operation in cycle t SHALL produce rsp_valid in cycle t+LAT.
REQ-026 Results SHALL return in issue order, and back-to-back issues SHALL yield back-to-back responses at full throughput of 1 per cycle.
REQ-027 busy SHALL be the OR of all tag valid bits.
REQ-028 issue_cnt SHALL increment by 1 per acceptance and saturate at 16'hFFFF.
REQ-029 The block SHALL NOT inspect FP32 values; NaN, Inf and zero handling belong to the adder.
REQ-030 When all requesters are continuously valid, each SHALL be granted exactly once every N_REQ cycles.

Reset
REQ-031 While rst_n=0: rr=0, all tag valid bits=0, issue_cnt=0, rsp_valid=0, busy=0, and req_ready=0 for all requesters.
REQ-032 Asserting rst_n mid-operation SHALL discard in-flight tags; those operations SHALL never raise rsp_valid.
REQ-033 The first grant after reset release SHALL favour requester 0.

Verification
REQ-034 Single request: requester 2 presents 3F800000 + 40000000 for one cycle -> req_ready[2]=1 that cycle; LAT cycles later rsp_valid=1, rsp_id=2, rsp_data=40400000; issue_cnt=1.
REQ-035 All 4 requesters valid for 8 cycles from reset -> grant order 0,1,2,3,0,1,2,3; 8 rsp_valid pulses carry the same id order, with no gaps.
REQ-036 Sparse contention: only requesters 1 and 3 valid, with rr=2 -> 3 is granted, then 1, then 3.
REQ-037 Reset mid-flight: issue 2 ops back-to-back, then assert rst_n=0 in the next cycle -> rsp_valid stays 0, busy=0, issue_cnt=0, rr=0.
REQ-038 Saturation: force 65540 acceptances -> issue_cnt reads FFFF and holds.
REQ-039 Idle: no req_valid -> add_a=add_b=0, req_ready=0, rr unchanged, busy=0 once the pipeline drains.
